// File: rtl/transport_mux_send.sv
`default_nettype none
// ============================================================================
//  Module   : transport_mux_send
//  Purpose  : Multiplexes several session channels onto one byte-wide link.
//             Each channel stages one command/data word; a round-robin FSM
//             emits a header byte followed by the data word, MSB byte first.
//  Revision : 1.0  initial release
// ============================================================================
module transport_mux_send #(
    parameter int CHANNELS   = 2,
    parameter int DATA_WIDTH = 16
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [2*CHANNELS-1:0]          cmd_in,
    input  logic [DATA_WIDTH*CHANNELS-1:0] data_in,
    input  logic                           send_en,
    output logic [CHANNELS-1:0]            busy,
    output logic                           sending,
    output logic [7:0]                     packetOut,
    output logic [15:0]                    pkt_count
);

    localparam int NBYTES = DATA_WIDTH / 8;
    localparam int CW     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int IW     = (NBYTES > 1) ? $clog2(NBYTES) : 1;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_HEADER = 2'd1,
        S_DATA   = 2'd2
    } state_t;

    state_t                r_state;
    logic [CW-1:0]         r_grant;
    logic [CW-1:0]         r_last;
    logic [IW-1:0]         r_idx;
    logic [1:0]            r_stage_cmd  [CHANNELS];
    logic [DATA_WIDTH-1:0] r_stage_data [CHANNELS];

    logic                  w_any;
    logic [CW-1:0]         w_sel;
    logic                  w_done;
    logic [CHANNELS-1:0]   w_clear;
    logic [DATA_WIDTH-1:0] w_shifted;
    logic [7:0]            w_byte;
    logic [7:0]            w_header;

    // Round-robin search for the next busy channel, starting after last grant.
    always_comb begin
        w_any = 1'b0;
        w_sel = '0;
        for (int k = 1; k <= CHANNELS; k++) begin
            if (!w_any && busy[(int'(r_last) + k) % CHANNELS]) begin
                w_any = 1'b1;
                w_sel = CW'((int'(r_last) + k) % CHANNELS);
            end
        end
    end

    // Final data byte leaves this edge: release the granted channel.
    always_comb begin
        w_done  = (r_state == S_DATA) && send_en && (r_idx == IW'(NBYTES - 1));
        w_clear = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            w_clear[c] = w_done && (r_grant == CW'(c));
        end
    end

    // Byte selection: shift the staged word so the current byte sits on top.
    always_comb begin
        w_shifted = r_stage_data[r_grant] << {r_idx, 3'b000};
        w_byte    = w_shifted[DATA_WIDTH-1 -: 8];
        w_header  = {1'b1, 3'(r_grant), 2'b00, r_stage_cmd[r_grant]};
    end

    // Per-channel staging; a channel may re-capture on the edge its busy clears.
    always_ff @(posedge clk) begin
        if (!reset) begin
            busy <= '0;
            for (int c = 0; c < CHANNELS; c++) begin
                r_stage_cmd[c]  <= '0;
                r_stage_data[c] <= '0;
            end
        end else begin
            for (int c = 0; c < CHANNELS; c++) begin
                if ((cmd_in[2*c +: 2] != 2'b00) && (!busy[c] || w_clear[c])) begin
                    r_stage_cmd[c]  <= cmd_in[2*c +: 2];
                    r_stage_data[c] <= data_in[DATA_WIDTH*c +: DATA_WIDTH];
                    busy[c]         <= 1'b1;
                end else if (w_clear[c]) begin
                    busy[c] <= 1'b0;
                end
            end
        end
    end

    // Control FSM with registered link outputs and packet counter.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state   <= S_IDLE;
            r_grant   <= '0;
            r_last    <= CW'(CHANNELS - 1);
            r_idx     <= '0;
            sending   <= 1'b0;
            packetOut <= 8'h00;
            pkt_count <= 16'h0000;
        end else begin
            sending <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_any) begin
                        r_grant <= w_sel;
                        r_state <= S_HEADER;
                    end
                end
                S_HEADER: begin
                    if (send_en) begin
                        sending   <= 1'b1;
                        packetOut <= w_header;
                        r_idx     <= '0;
                        r_state   <= S_DATA;
                    end
                end
                S_DATA: begin
                    if (send_en) begin
                        sending   <= 1'b1;
                        packetOut <= w_byte;
                        if (w_done) begin
                            r_idx     <= '0;
                            r_last    <= r_grant;
                            pkt_count <= pkt_count + 16'd1;
                            r_state   <= S_IDLE;
                        end else begin
                            r_idx <= r_idx + IW'(1);
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_transport_mux_send.sv
`default_nettype none
// ============================================================================
//  Module   : tb_transport_mux_send
//  Purpose  : Self-checking bench for transport_mux_send (2 channels, 16 bit).
//  Revision : 1.0  initial release
// ============================================================================
module tb_transport_mux_send;

    localparam int CH = 2;
    localparam int DW = 16;

    logic            clk;
    logic            reset;
    logic [2*CH-1:0] cmd_in;
    logic [DW*CH-1:0] data_in;
    logic            send_en;
    logic [CH-1:0]   busy;
    logic            sending;
    logic [7:0]      packetOut;
    logic [15:0]     pkt_count;

    transport_mux_send #(.CHANNELS(CH), .DATA_WIDTH(DW)) dut (
        .clk       (clk),
        .reset     (reset),
        .cmd_in    (cmd_in),
        .data_in   (data_in),
        .send_en   (send_en),
        .busy      (busy),
        .sending   (sending),
        .packetOut (packetOut),
        .pkt_count (pkt_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int         n_vec = 0;
    int         n_err = 0;
    logic [7:0] exp_q[$];
    int         exp_pkt = 0;

    typedef struct {
        int          ch;
        logic [1:0]  cmd;
        logic [15:0] data;
        logic [7:0]  hdr;
    } vec_t;

    vec_t vecs [6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_pkt(input logic [7:0] hdr, input logic [15:0] d);
        exp_q.push_back(hdr);
        exp_q.push_back(d[15:8]);
        exp_q.push_back(d[7:0]);
    endtask

    task automatic set_ch(input int ch, input logic [1:0] cmd, input logic [15:0] d);
        cmd_in[2*ch +: 2]   = cmd;
        data_in[DW*ch +: DW] = d;
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || busy != '0) && n < 100) begin
            tick();
            n++;
        end
        chk(name, 32'(exp_q.size()), 32'd0);
    endtask

    // Scoreboard: every emitted link byte must match the next expected byte.
    always begin
        @(posedge clk);
        #1;
        if (sending) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_byte", {24'h0, packetOut}, 32'hFFFF_FFFF);
            end else begin
                chk("link_byte", {24'h0, packetOut}, {24'h0, exp_q.pop_front()});
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [8:0] exp_send;
        int         n;

        vecs[0] = '{0, 2'b01, 16'hABCD, 8'h81};
        vecs[1] = '{1, 2'b11, 16'h2222, 8'h93};
        vecs[2] = '{0, 2'b10, 16'h1111, 8'h82};
        vecs[3] = '{1, 2'b01, 16'hBEEF, 8'h91};
        vecs[4] = '{0, 2'b11, 16'h0000, 8'h83};
        vecs[5] = '{1, 2'b10, 16'hFFFF, 8'h92};

        // Reset with a command pending: nothing may be captured.
        reset   = 1'b0;
        send_en = 1'b1;
        cmd_in  = '0;
        data_in = '0;
        set_ch(0, 2'b01, 16'h5A5A);
        tick();
        tick();
        chk("rst_busy", {30'h0, busy}, 32'h0);
        chk("rst_sending", {31'h0, sending}, 32'h0);
        chk("rst_packetOut", {24'h0, packetOut}, 32'h0);
        chk("rst_pkt_count", {16'h0, pkt_count}, 32'h0);
        cmd_in = '0;
        reset  = 1'b1;
        tick();
        tick();
        chk("no_capture_in_reset", {30'h0, busy}, 32'h0);

        // Table: one packet per vector, exact cycle timing checked.
        for (int i = 0; i < 6; i++) begin
            set_ch(vecs[i].ch, vecs[i].cmd, vecs[i].data);
            push_pkt(vecs[i].hdr, vecs[i].data);
            exp_pkt++;
            tick();
            chk("vec_busy_set", {31'h0, busy[vecs[i].ch]}, 32'h1);
            cmd_in = '0;
            tick();
            chk("vec_grant_gap", {31'h0, sending}, 32'h0);
            tick();
            chk("vec_hdr_send", {31'h0, sending}, 32'h1);
            tick();
            chk("vec_d0_send", {31'h0, sending}, 32'h1);
            tick();
            chk("vec_d1_send", {31'h0, sending}, 32'h1);
            chk("vec_busy_clr", {30'h0, busy}, 32'h0);
            chk("vec_pkt_count", {16'h0, pkt_count}, 32'(exp_pkt));
        end

        // Simultaneous requests right after reset: ch0 wins, then ch1.
        reset = 1'b0;
        tick();
        reset   = 1'b1;
        exp_pkt = 0;
        tick();
        set_ch(0, 2'b10, 16'h1111);
        set_ch(1, 2'b11, 16'h2222);
        push_pkt(8'h82, 16'h1111);
        push_pkt(8'h93, 16'h2222);
        exp_pkt  = 2;
        exp_send = 9'b111_0_111_00;
        for (int e = 0; e < 9; e++) begin
            tick();
            if (e == 0) begin
                chk("sim_busy_both", {30'h0, busy}, 32'h3);
                cmd_in = '0;
            end
            chk("sim_sending", {31'h0, sending}, {31'h0, exp_send[e]});
        end
        chk("sim_pkt_count", {16'h0, pkt_count}, 32'(exp_pkt));
        chk("sim_busy_clr", {30'h0, busy}, 32'h0);

        // Fairness: both channels re-request continuously; grants alternate.
        set_ch(0, 2'b01, 16'h0A0A);
        set_ch(1, 2'b10, 16'h0B0B);
        for (int p = 0; p < 3; p++) begin
            push_pkt(8'h81, 16'h0A0A);
            push_pkt(8'h92, 16'h0B0B);
        end
        n = 0;
        while (pkt_count != 16'(exp_pkt + 4) && n < 200) begin
            tick();
            n++;
        end
        chk("fair_progress", {16'h0, pkt_count}, 32'(exp_pkt + 4));
        cmd_in  = '0;
        exp_pkt = exp_pkt + 6;
        drain("fair_drain");
        chk("fair_pkt_count", {16'h0, pkt_count}, 32'(exp_pkt));

        // Stall three cycles after the header.
        set_ch(1, 2'b01, 16'h1234);
        push_pkt(8'h91, 16'h1234);
        exp_pkt++;
        tick();
        cmd_in = '0;
        tick();
        tick();
        chk("stall_hdr", {31'h0, sending}, 32'h1);
        send_en = 1'b0;
        for (int s = 0; s < 3; s++) begin
            tick();
            chk("stall_sending", {31'h0, sending}, 32'h0);
            chk("stall_hold_byte", {24'h0, packetOut}, 32'h91);
            chk("stall_busy", {31'h0, busy[1]}, 32'h1);
        end
        send_en = 1'b1;
        tick();
        chk("stall_d0", {31'h0, sending}, 32'h1);
        chk("stall_busy_mid", {31'h0, busy[1]}, 32'h1);
        tick();
        chk("stall_d1", {31'h0, sending}, 32'h1);
        chk("stall_busy_end", {31'h0, busy[1]}, 32'h0);
        chk("stall_pkt_count", {16'h0, pkt_count}, 32'(exp_pkt));

        // Command while busy is dropped.
        set_ch(0, 2'b10, 16'h6789);
        push_pkt(8'h82, 16'h6789);
        exp_pkt++;
        tick();
        set_ch(0, 2'b01, 16'h5555);
        tick();
        cmd_in = '0;
        drain("drop_drain");
        for (int s = 0; s < 4; s++) begin
            tick();
            chk("drop_no_send", {31'h0, sending}, 32'h0);
        end
        chk("drop_busy", {30'h0, busy}, 32'h0);
        chk("drop_pkt_count", {16'h0, pkt_count}, 32'(exp_pkt));

        // Reset in the middle of the data bytes aborts the packet.
        set_ch(1, 2'b11, 16'hAA55);
        exp_q.push_back(8'h93);
        exp_q.push_back(8'hAA);
        tick();
        cmd_in = '0;
        tick();
        tick();
        tick();
        chk("abort_d0_send", {31'h0, sending}, 32'h1);
        reset = 1'b0;
        tick();
        chk("abort_sending", {31'h0, sending}, 32'h0);
        chk("abort_busy", {30'h0, busy}, 32'h0);
        chk("abort_pkt_count", {16'h0, pkt_count}, 32'h0);
        chk("abort_packetOut", {24'h0, packetOut}, 32'h0);
        reset = 1'b1;
        for (int s = 0; s < 4; s++) begin
            tick();
            chk("abort_quiet", {31'h0, sending}, 32'h0);
        end
        chk("abort_queue", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
